mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Holds one instruction per cycle in a valid/allowin pipeline register.
- Receives the data-SRAM read data for loads issued by the execute stage one cycle earlier. Extracts and extends the loaded byte, halfword or word; non-loads pass the ALU result through.
- Produces the write-back payload and exports destination, write-enable and data toward decode for hazard and forwarding logic.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- LD_OP_W, 5, width of the one-hot load-type bundle: bit0 ld.b, bit1 ld.h, bit2 ld.w, bit3 ld.bu, bit4 ld.hu.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ws_allowin  in  1  write-back stage can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute stage presents a valid instruction
- es_pc  in  32  instruction PC
- es_rf_we  in  1  instruction writes the register file
- es_rf_waddr  in  5  destination register
- es_alu_result  in  32  ALU result / memory address
- es_res_from_mem  in  1  instruction is a load
- es_ld_op  in  LD_OP_W  one-hot load type, valid when es_res_from_mem=1
- data_sram_rdata  in  32  SRAM read data, valid in the cycle the load occupies this stage
- ms_to_ws_valid  out  1  valid instruction for write-back
- ms_pc  out  32  latched PC
- ms_rf_we  out  1  register write enable, gated by valid
- ms_rf_waddr  out  5  latched destination
- ms_rf_wdata  out  32  final write data
- ms_res_from_mem  out  1  load in this stage, gated by valid (feeds decode load-use detection)

Behaviour:
- Handshake:
  - ms_ready_go is constant 1; no internal stall source.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Valid register:
  - Synchronous reset clears ms_valid to 0.
  - Otherwise, when ms_allowin=1, ms_valid <= es_to_ms_valid.
  - When ms_allowin=0, ms_valid holds.
- Payload registers:
  - Registers: pc, rf_we, rf_waddr, alu_result, res_from_mem, ld_op.
  - Load only when es_to_ms_valid && ms_allowin; otherwise hold.
  - On reset all clear to 0.
- Reset values of outputs:
  - ms_allowin=1.
  - ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_res_from_mem all 0.
  - ms_rf_wdata=0: the ALU result register is 0 and it is not a load.
- Gating:
  - ms_rf_we = ms_valid && rf_we_r.
  - ms_res_from_mem = ms_valid && res_from_mem_r.
  - A bubble therefore never signals a write or a load.
- Load extraction uses a = alu_result_r[1:0]:
  - byte = rdata[8*a+7 : 8*a].
  - half = a[1] ? rdata[31:16] : rdata[15:0]; a[0] is ignored, since misalignment is handled upstream.
  - ld.b: sign-extend byte. ld.bu: zero-extend byte.
  - ld.h: sign-extend half. ld.hu: zero-extend half.
  - ld.w: rdata unchanged.
  - If ld_op is all-zero or not one-hot while res_from_mem=1, treat as ld.w.
- ms_rf_wdata = res_from_mem_r ? extracted load value : alu_result_r. Purely combinational from the registers and data_sram_rdata, with no added latency.
- Latency: one cycle from acceptance to ms_to_ws_valid when ws_allowin=1.
- Back-pressure:
  - When ws_allowin=0 and ms_valid=1, the stage holds all state and ms_allowin=0.
  - The SRAM read data is not re-captured. The SRAM interface holds rdata stable until the stage advances; the write-back stage is responsible for not back-pressuring a load for more than its hold window.
- Simultaneous events:
  - A new instruction accepted in the same cycle the current one leaves replaces the payload; there is no bubble.
  - With es_to_ms_valid=0 and ms_allowin=1, ms_valid drops to 0 and the payload holds its old values, masked by gating.
- Reset mid-operation: an in-flight instruction is discarded in the same clock edge; no write is exported afterwards.

Test Plan:
- Reset: resetn=0 for 2 cycles with es_to_ms_valid=1 -> ms_to_ws_valid=0, ms_rf_we=0, ms_pc=0, ms_allowin=1.
- Non-load passthrough: accept pc=0x1c000010, rf_we=1, waddr=5, alu_result=0x12345678, ws_allowin=1 -> next cycle ms_to_ws_valid=1, ms_rf_wdata=0x12345678, ms_rf_waddr=5.
- Byte loads: rdata=0x80F17F01, addr low bits 0..3 -> ld.b yields 0x00000001, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80; ld.bu at addr 3 -> 0x00000080.
- Halfword loads: rdata=0x8001F00F -> ld.h addr 0 -> 0xFFFFF00F; ld.hu addr 2 -> 0x00008001; ld.w -> 0x8001F00F.
- Back-pressure: ws_allowin=0 for 3 cycles with a valid instruction held -> ms_allowin=0, outputs stable; the upstream instruction is not accepted until ws_allowin=1, then both flow in order.
- Bubble and mid-flight reset: es_to_ms_valid=0 after an rf_we=1 instruction -> ms_rf_we=0 next cycle. Asserting resetn=0 while a load is valid -> ms_res_from_mem=0 and ms_to_ws_valid=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute-stage instruction, extracts
// and extends load data from the data SRAM, and exports the write-back payload.
module mem_stage #(
   parameter int DATA_W  = 32,
   parameter int LD_OP_W = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                ws_allowin,
   output logic                ms_allowin,
   input  logic                es_to_ms_valid,
   input  logic [DATA_W-1:0]   es_pc,
   input  logic                es_rf_we,
   input  logic [4:0]          es_rf_waddr,
   input  logic [DATA_W-1:0]   es_alu_result,
   input  logic                es_res_from_mem,
   input  logic [LD_OP_W-1:0]  es_ld_op,
   input  logic [DATA_W-1:0]   data_sram_rdata,
   output logic                ms_to_ws_valid,
   output logic [DATA_W-1:0]   ms_pc,
   output logic                ms_rf_we,
   output logic [4:0]          ms_rf_waddr,
   output logic [DATA_W-1:0]   ms_rf_wdata,
   output logic                ms_res_from_mem
);

   localparam logic [LD_OP_W-1:0] OP_B  = LD_OP_W'(1) << 0;
   localparam logic [LD_OP_W-1:0] OP_H  = LD_OP_W'(1) << 1;
   localparam logic [LD_OP_W-1:0] OP_W  = LD_OP_W'(1) << 2;
   localparam logic [LD_OP_W-1:0] OP_BU = LD_OP_W'(1) << 3;
   localparam logic [LD_OP_W-1:0] OP_HU = LD_OP_W'(1) << 4;

   logic                ms_valid;
   logic                ms_ready_go;
   logic [DATA_W-1:0]   pc_r;
   logic                rf_we_r;
   logic [4:0]          rf_waddr_r;
   logic [DATA_W-1:0]   alu_result_r;
   logic                res_from_mem_r;
   logic [LD_OP_W-1:0]  ld_op_r;

   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [DATA_W-1:0]   load_value;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_r           <= '0;
         rf_we_r        <= 1'b0;
         rf_waddr_r     <= '0;
         alu_result_r   <= '0;
         res_from_mem_r <= 1'b0;
         ld_op_r        <= '0;
      end else if (es_to_ms_valid && ms_allowin) begin
         pc_r           <= es_pc;
         rf_we_r        <= es_rf_we;
         rf_waddr_r     <= es_rf_waddr;
         alu_result_r   <= es_alu_result;
         res_from_mem_r <= es_res_from_mem;
         ld_op_r        <= es_ld_op;
      end
   end

   always_comb begin
      byte_sel = data_sram_rdata[7:0];
      case (alu_result_r[1:0])
         2'd0:    byte_sel = data_sram_rdata[7:0];
         2'd1:    byte_sel = data_sram_rdata[15:8];
         2'd2:    byte_sel = data_sram_rdata[23:16];
         default: byte_sel = data_sram_rdata[31:24];
      endcase
      // a[0] is ignored: misaligned halfwords are trapped before this stage
      half_sel = alu_result_r[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
   end

   always_comb begin
      load_value = data_sram_rdata;
      // zero or multi-hot load types fall through to the full-word case
      case (ld_op_r)
         OP_B:    load_value = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         OP_BU:   load_value = {{(DATA_W-8){1'b0}}, byte_sel};
         OP_H:    load_value = {{(DATA_W-16){half_sel[15]}}, half_sel};
         OP_HU:   load_value = {{(DATA_W-16){1'b0}}, half_sel};
         OP_W:    load_value = data_sram_rdata;
         default: load_value = data_sram_rdata;
      endcase
   end

   assign ms_pc           = pc_r;
   assign ms_rf_waddr     = rf_waddr_r;
   assign ms_rf_we        = ms_valid && rf_we_r;
   assign ms_res_from_mem = ms_valid && res_from_mem_r;
   assign ms_rf_wdata     = res_from_mem_r ? load_value : alu_result_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, passthrough, load
// extraction, back-pressure, bubbles and mid-flight reset.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_pc;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_alu_result;
   logic        es_res_from_mem;
   logic [4:0]  es_ld_op;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        ms_res_from_mem;

   int tests_run;
   int tests_failed;

   mem_stage #(.DATA_W(32), .LD_OP_W(5)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_pc           (es_pc),
      .es_rf_we        (es_rf_we),
      .es_rf_waddr     (es_rf_waddr),
      .es_alu_result   (es_alu_result),
      .es_res_from_mem (es_res_from_mem),
      .es_ld_op        (es_ld_op),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_pc           (ms_pc),
      .ms_rf_we        (ms_rf_we),
      .ms_rf_waddr     (ms_rf_waddr),
      .ms_rf_wdata     (ms_rf_wdata),
      .ms_res_from_mem (ms_res_from_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] alu,
                        input logic mem, input logic [4:0] op);
      es_to_ms_valid  = v;
      es_pc           = pc;
      es_rf_we        = we;
      es_rf_waddr     = wa;
      es_alu_result   = alu;
      es_res_from_mem = mem;
      es_ld_op        = op;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      ws_allowin = 1'b1;
      data_sram_rdata = 32'hDEADBEEF;
      drive(1'b1, 32'h1c000000, 1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'b0);
      cyc();
      cyc();
      tests_run++;
      if (ms_to_ws_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid);
      end
      tests_run++;
      if (ms_rf_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_rf_we got=%b exp=0", ms_rf_we);
      end
      tests_run++;
      if (ms_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_pc got=%h exp=00000000", ms_pc);
      end
      tests_run++;
      if (ms_allowin !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_allowin got=%b exp=1", ms_allowin);
      end
      tests_run++;
      if (ms_rf_wdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_wdata got=%h exp=00000000", ms_rf_wdata);
      end
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      resetn = 1'b1;
      cyc();
   endtask

   task automatic test_passthrough();
      drive(1'b1, 32'h1c000010, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_to_ws_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL pass_pre_valid got=%b exp=0", ms_to_ws_valid);
      end
      cyc();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_to_ws_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL pass_valid got=%b exp=1", ms_to_ws_valid);
      end
      tests_run++;
      if (ms_rf_wdata !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL pass_wdata got=%h exp=12345678", ms_rf_wdata);
      end
      tests_run++;
      if (ms_rf_waddr !== 5'd5) begin
         tests_failed++;
         $display("FAIL pass_waddr got=%0d exp=5", ms_rf_waddr);
      end
      tests_run++;
      if (ms_pc !== 32'h1c000010 || ms_rf_we !== 1'b1 || ms_res_from_mem !== 1'b0) begin
         tests_failed++;
         $display("FAIL pass_ctrl got pc=%h we=%b mem=%b exp pc=1c000010 we=1 mem=0",
                  ms_pc, ms_rf_we, ms_res_from_mem);
      end
      cyc();
   endtask

   task automatic test_loads();
      logic [31:0] rd   [0:10];
      logic [1:0]  addr [0:10];
      logic [4:0]  op   [0:10];
      logic [31:0] exp  [0:10];
      rd[0] = 32'h80F17F01; addr[0] = 2'd0; op[0] = 5'b00001; exp[0] = 32'h00000001;
      rd[1] = 32'h80F17F01; addr[1] = 2'd1; op[1] = 5'b00001; exp[1] = 32'h0000007F;
      rd[2] = 32'h80F17F01; addr[2] = 2'd2; op[2] = 5'b00001; exp[2] = 32'hFFFFFFF1;
      rd[3] = 32'h80F17F01; addr[3] = 2'd3; op[3] = 5'b00001; exp[3] = 32'hFFFFFF80;
      rd[4] = 32'h80F17F01; addr[4] = 2'd3; op[4] = 5'b01000; exp[4] = 32'h00000080;
      rd[5] = 32'h8001F00F; addr[5] = 2'd0; op[5] = 5'b00010; exp[5] = 32'hFFFFF00F;
      rd[6] = 32'h8001F00F; addr[6] = 2'd2; op[6] = 5'b10000; exp[6] = 32'h00008001;
      rd[7] = 32'h8001F00F; addr[7] = 2'd0; op[7] = 5'b00100; exp[7] = 32'h8001F00F;
      rd[8] = 32'h8001F00F; addr[8] = 2'd1; op[8] = 5'b00010; exp[8] = 32'hFFFFF00F;
      rd[9] = 32'h8001F00F; addr[9] = 2'd2; op[9] = 5'b00000; exp[9] = 32'h8001F00F;
      rd[10] = 32'h8001F00F; addr[10] = 2'd2; op[10] = 5'b00011; exp[10] = 32'h8001F00F;
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 32'h1c000100 + 32'(i * 4), 1'b1, 5'd7, {30'h04000000, addr[i]},
               1'b1, op[i]);
         data_sram_rdata = 32'h0;
         cyc();
         drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
         data_sram_rdata = rd[i];
         #1;
         tests_run++;
         if (ms_rf_wdata !== exp[i] || ms_res_from_mem !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_%0d op=%b a=%0d got=%h mem=%b exp=%h mem=1",
                     i, op[i], addr[i], ms_rf_wdata, ms_res_from_mem, exp[i]);
         end
      end
      cyc();
   endtask

   task automatic test_back_pressure();
      drive(1'b1, 32'h1c000200, 1'b1, 5'd9, 32'h00000AAA, 1'b0, 5'b0);
      cyc();
      ws_allowin = 1'b0;
      drive(1'b1, 32'h1c000204, 1'b1, 5'd10, 32'h00000BBB, 1'b0, 5'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_pc !== 32'h1c000200 ||
             ms_rf_wdata !== 32'h00000AAA || ms_rf_waddr !== 5'd9) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d got allowin=%b v=%b pc=%h wd=%h wa=%0d exp 0 1 1c000200 00000aaa 9",
                     i, ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_wdata, ms_rf_waddr);
         end
         cyc();
      end
      ws_allowin = 1'b1;
      #1;
      tests_run++;
      if (ms_allowin !== 1'b1 || ms_pc !== 32'h1c000200) begin
         tests_failed++;
         $display("FAIL bp_release got allowin=%b pc=%h exp 1 1c000200", ms_allowin, ms_pc);
      end
      cyc();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_to_ws_valid !== 1'b1 || ms_pc !== 32'h1c000204 || ms_rf_wdata !== 32'h00000BBB) begin
         tests_failed++;
         $display("FAIL bp_second got v=%b pc=%h wd=%h exp 1 1c000204 00000bbb",
                  ms_to_ws_valid, ms_pc, ms_rf_wdata);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h1c000300, 1'b1, 5'd1, 32'h11111111, 1'b0, 5'b0);
      cyc();
      drive(1'b1, 32'h1c000304, 1'b1, 5'd2, 32'h22222222, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_pc !== 32'h1c000300 || ms_allowin !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_first got pc=%h allowin=%b exp 1c000300 1", ms_pc, ms_allowin);
      end
      cyc();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_to_ws_valid !== 1'b1 || ms_pc !== 32'h1c000304 || ms_rf_waddr !== 5'd2) begin
         tests_failed++;
         $display("FAIL b2b_second got v=%b pc=%h wa=%0d exp 1 1c000304 2",
                  ms_to_ws_valid, ms_pc, ms_rf_waddr);
      end
      cyc();
   endtask

   task automatic test_bubble();
      drive(1'b1, 32'h1c000400, 1'b1, 5'd12, 32'h0000CAFE, 1'b0, 5'b0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      #1;
      tests_run++;
      if (ms_rf_we !== 1'b1) begin
         tests_failed++;
         $display("FAIL bubble_pre_we got=%b exp=1", ms_rf_we);
      end
      cyc();
      tests_run++;
      if (ms_rf_we !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bubble_we got we=%b v=%b exp 0 0", ms_rf_we, ms_to_ws_valid);
      end
      tests_run++;
      if (ms_pc !== 32'h1c000400 || ms_rf_waddr !== 5'd12) begin
         tests_failed++;
         $display("FAIL bubble_hold got pc=%h wa=%0d exp 1c000400 12", ms_pc, ms_rf_waddr);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 32'h1c000500, 1'b1, 5'd20, 32'h00001000, 1'b1, 5'b00100);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'b0);
      data_sram_rdata = 32'h5A5A5A5A;
      #1;
      tests_run++;
      if (ms_res_from_mem !== 1'b1 || ms_rf_wdata !== 32'h5A5A5A5A) begin
         tests_failed++;
         $display("FAIL midrst_pre got mem=%b wd=%h exp 1 5a5a5a5a", ms_res_from_mem, ms_rf_wdata);
      end
      resetn = 1'b0;
      cyc();
      tests_run++;
      if (ms_res_from_mem !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_rf_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst got mem=%b v=%b we=%b exp 0 0 0",
                  ms_res_from_mem, ms_to_ws_valid, ms_rf_we);
      end
      tests_run++;
      if (ms_rf_wdata !== 32'h0 || ms_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL midrst_clear got wd=%h pc=%h exp 00000000 00000000", ms_rf_wdata, ms_pc);
      end
      resetn = 1'b1;
      cyc();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_passthrough();
      test_loads();
      test_back_pressure();
      test_back_to_back();
      test_bubble();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
